// File: rtl/addr_cycle_monitor_pkg.sv
// drv_mon_pkg: shared types, defaults and the bin-index helper used by the
// address-side and vector-side cycle monitors.
package drv_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2
  } mon_state_t;

  localparam int          DEF_MON_CNT_RANGE = 8;
  localparam int          DEF_MON_CNT_SIZE  = 16;
  localparam int          DEF_MAX_CYCLE_CNT = 128;
  localparam logic [15:0] INTERVAL_SAT      = 16'hFFFF;

  // Clamped histogram bin for an interval; anything at or beyond the span
  // lands in the last (overflow) bin. range is a power of two, so the divide
  // folds to a shift once the arguments are elaboration constants.
  function automatic int unsigned mon_bin_idx(input logic [15:0] interval,
                                              input int unsigned range,
                                              input int unsigned max_cnt);
    int unsigned iv;
    iv = 32'(interval);
    if (iv >= max_cnt) return (max_cnt / range) - 1;
    else               return iv / range;
  endfunction

endpackage

// File: rtl/addr_cycle_monitor_if.sv
// addr_cycle_monitor_if: control and event strobes feeding one monitor.
// evt is the observed address event (address issue or address-FIFO write).
interface addr_cycle_monitor_if;
  logic start;
  logic stop;
  logic evt;

  modport master (output start, output stop, output evt);
  modport slave  (input  start, input  stop, input  evt);
endinterface

// File: rtl/addr_cycle_monitor_mon_sat_counter.sv
// mon_sat_counter: histogram bin counter that sticks at all-ones.
module mon_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;

  // Clear has priority over increment; increments stop at all-ones.
  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/addr_cycle_monitor.sv
// addr_cycle_monitor: measures spacing in cycles between consecutive address
// events and bins it into a histogram of saturating counters.
// Min/max interval tracking is built only when ADDR_CYCLE_MON_MINMAX_EN is
// defined; otherwise min_interval_o is tied to 16'hFFFF and max_interval_o to 0.
//
// state   | meaning
// --------+------------------------------------------
// IDLE    | histogram held, events ignored
// ARMED   | waiting for the first event after start
// MEASURE | timing intervals between events
module addr_cycle_monitor
  import drv_mon_pkg::*;
#(
  parameter int MON_CNT_RANGE = DEF_MON_CNT_RANGE,
  parameter int MON_CNT_SIZE  = DEF_MON_CNT_SIZE,
  parameter int MAX_CYCLE_CNT = DEF_MAX_CYCLE_CNT
) (
  input  logic                    clk,
  input  logic                    reset,
  addr_cycle_monitor_if.slave     mon_if,
  output logic [MON_CNT_SIZE-1:0] mon_cnts_o [MAX_CYCLE_CNT/MON_CNT_RANGE],
  output logic [15:0]             cycle_cnt_o,
  output logic [15:0]             event_total_o,
  output logic [15:0]             min_interval_o,
  output logic [15:0]             max_interval_o,
  output logic                    busy_o
);

  localparam int NUM_BINS = MAX_CYCLE_CNT / MON_CNT_RANGE;

  mon_state_t  state_q, state_d;
  logic        busy_q;
  logic        clr_all;
  logic        count_evt;
  logic        take_interval;
  logic [15:0] gap_q;
  logic [15:0] interval;
  int unsigned bin_idx;
  logic [15:0] cycle_cnt_q;
  logic [15:0] event_total_q;

  // State register; busy is registered from the next state so it tracks
  // start/stop with one cycle of latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  // Next state and per-cycle strobes; start overrides stop and event.
  always_comb begin
    state_d       = state_q;
    clr_all       = 1'b0;
    count_evt     = 1'b0;
    take_interval = 1'b0;
    if (mon_if.start) begin
      clr_all = 1'b1;
      state_d = ARMED;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        ARMED: begin
          if (mon_if.evt) begin
            count_evt = 1'b1;
            state_d   = MEASURE;
          end
          if (mon_if.stop) state_d = IDLE;
        end
        MEASURE: begin
          if (mon_if.evt) begin
            count_evt     = 1'b1;
            take_interval = 1'b1;
          end
          if (mon_if.stop) state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Gap counter: cycles elapsed since the last event, held outside MEASURE.
  always_ff @(posedge clk) begin
    if (reset || clr_all) begin
      gap_q <= '0;
    end else if (count_evt) begin
      gap_q <= '0;
    end else if ((state_q == MEASURE) && (gap_q != INTERVAL_SAT)) begin
      gap_q <= gap_q + 16'd1;
    end
  end

  assign interval = (gap_q == INTERVAL_SAT) ? INTERVAL_SAT : gap_q + 16'd1;
  assign bin_idx  = mon_bin_idx(interval, unsigned'(MON_CNT_RANGE),
                                unsigned'(MAX_CYCLE_CNT));

  for (genvar gi = 0; gi < NUM_BINS; gi++) begin : g_bin
    mon_sat_counter #(
      .WIDTH (MON_CNT_SIZE)
    ) u_cnt (
      .clk   (clk),
      .reset (reset),
      .clr_i (clr_all),
      .inc_i (take_interval && (bin_idx == unsigned'(gi))),
      .cnt_o (mon_cnts_o[gi])
    );
  end

  // Last measured interval and saturating event total.
  always_ff @(posedge clk) begin
    if (reset || clr_all) begin
      cycle_cnt_q   <= '0;
      event_total_q <= '0;
    end else begin
      if (take_interval) cycle_cnt_q <= interval;
      if (count_evt && (event_total_q != 16'hFFFF)) begin
        event_total_q <= event_total_q + 16'd1;
      end
    end
  end

`ifdef ADDR_CYCLE_MON_MINMAX_EN
  logic [15:0] min_q;
  logic [15:0] max_q;

  // Extreme intervals since the last start.
  always_ff @(posedge clk) begin
    if (reset || clr_all) begin
      min_q <= 16'hFFFF;
      max_q <= 16'h0000;
    end else if (take_interval) begin
      if (interval < min_q) min_q <= interval;
      if (interval > max_q) max_q <= interval;
    end
  end

  assign min_interval_o = min_q;
  assign max_interval_o = max_q;
`else
  assign min_interval_o = 16'hFFFF;
  assign max_interval_o = 16'h0000;
`endif

  assign cycle_cnt_o   = cycle_cnt_q;
  assign event_total_o = event_total_q;
  assign busy_o        = busy_q;

endmodule
